dram_port_arbiter: RTL and testbench
====================================

# dram_port_arbiter

Controller placed in front of the SoC's single-port DRAM macro (the `i_dram` bank at 0x8000_0000). It sequences the memory through two phases: an INIT phase where only the preload stream, driven by the ELF loader or a debug bridge, may write rows, and a RUN phase where the system AXI-to-mem port and late preload writes share the macro under round-robin arbitration. It also flags out-of-range preload addresses, replacing direct hierarchical pokes into the memory's `init_val`.

## Interface
- AddrWidth, 64: byte-address width of both requester ports.
- DataWidth, 256: row width in bits (64*NrLanes/2 with NrLanes=8).
- BaseAddr, 64'h8000_0000: first byte address mapped to row 0.
- NumWords, 2**25: rows in the macro (1 GiB / 32 B).
- Derived: BeWidth=DataWidth/8; ByteOff=$clog2(BeWidth); IdxWidth=$clog2(NumWords).
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- pl_valid_i  in  1  preload beat valid.
- pl_ready_o  out  1  preload beat accepted when valid&ready.
- pl_addr_i  in  AddrWidth  preload byte address.
- pl_data_i  in  DataWidth  preload row data.
- pl_last_i  in  1  final preload beat.
- sys_req_i  in  1  system access request.
- sys_gnt_o  out  1  system request granted this cycle.
- sys_we_i  in  1  1=write, 0=read.
- sys_addr_i  in  AddrWidth  system byte address.
- sys_wdata_i  in  DataWidth  system write data.
- sys_be_i  in  BeWidth  system byte enables.
- sys_rvalid_o  out  1  read data valid.
- sys_rdata_o  out  DataWidth  read data.
- mem_req_o  out  1  macro access.
- mem_we_o  out  1  macro write enable.
- mem_addr_o  out  IdxWidth  macro row index.
- mem_wdata_o  out  DataWidth  macro write data.
- mem_be_o  out  BeWidth  macro byte enables.
- mem_rdata_i  in  DataWidth  macro read data, 1-cycle latency.
- init_done_o  out  1  high in RUN.
- oob_err_o  out  1  sticky out-of-range preload flag.

## Operation
- Row index = (addr - BaseAddr) >> ByteOff, truncated to IdxWidth. The low ByteOff address bits are ignored.
- A preload address is in range iff BaseAddr <= addr < BaseAddr + NumWords*BeWidth.
- States:
  - INIT (reset): pl_ready_o=1 and sys_gnt_o=0.
  - INIT -> RUN on an accepted beat with pl_last_i=1, whether or not that beat is in range.
  - RUN is terminal until reset.
- Preload write: we=1, be=all ones, wdata=pl_data_i.
- Out-of-range preload beat: still accepted (pl_ready_o=1), no mem_req_o, oob_err_o set and held until reset.
- RUN arbitration is round-robin with a 1-bit last-winner register (lw, reset 0=preload).
  - If only one side requests, it wins.
  - If both request, the side that is not lw wins, and lw updates to the winner on every grant.
  - The loser sees pl_ready_o=0 or sys_gnt_o=0.
- System accesses drive be=sys_be_i. System addresses are not range-checked; index truncation wraps.
- Grant and ready are combinational from valid/req and registered state. mem_* are driven combinationally by the winner. mem_req_o=0 when there is no winner.

## Timing
- Granted system read in cycle N: sys_rvalid_o=1 in N+1 with sys_rdata_o=mem_rdata_i. There is no back-pressure. Writes produce no rvalid.
- Back-to-back system reads sustain one per cycle. The rvalid pipeline register is independent of arbitration.
- Preload throughput is one beat per cycle in INIT.
- The INIT->RUN transition takes effect the cycle after the last beat. The system can be granted at the earliest in that cycle.
- Reset values: state=INIT, lw=0, sys_rvalid_o=0, oob_err_o=0, init_done_o=0.
- Reset output state: pl_ready_o=1, sys_gnt_o=0, mem_req_o=0 (no pl_valid_i).
- Asynchronous reset mid-transfer: an in-flight read's rvalid is dropped and all state returns to INIT immediately.
- Simultaneous pl_last beat and sys_req in INIT: preload wins and the system waits one cycle.

## Test plan
- Preload 4 beats at 0x8000_0000, 0x8000_0020, 0x8000_0040, 0x8000_0060 (last on 4th) with sys_req_i=1 throughout -> mem idx 0..3 written with be=32'hFFFFFFFF, sys_gnt_o=0 until init_done_o rises the cycle after beat 4.
- RUN, system reads idx 2 -> sys_rvalid_o exactly one cycle after grant, sys_rdata_o = beat 3 data. Back-to-back reads of idx 0,1 -> rvalid on 2 consecutive cycles.
- RUN, pl_valid_i and sys_req_i held high for 6 cycles -> grants alternate sys, pl, sys, pl, sys, pl (lw=0 at entry).
- Preload beat at 0x7FFF_FFE0 then 0xC000_0000 with last -> no mem_req_o, oob_err_o=1 and sticky, transition to RUN still occurs.
- System write be=32'h0000_000F to 0x8000_0005 -> mem_addr_o=0, mem_be_o=0x0000000F.
- Assert rst_ni low for 1 ns mid-read -> sys_rvalid_o=0, init_done_o=0, oob_err_o=0 immediately. After release, state is INIT and pl_ready_o=1.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Front end for the single-port DRAM macro: preload-only INIT phase, then round-robin preload/system sharing in RUN.
// Grant/ready are combinational with no added request latency; read data returns one cycle after grant; the losing side is held off.
module dram_port_arbiter #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 256,
  parameter logic [AddrWidth-1:0] BaseAddr  = 64'h8000_0000,
  parameter int unsigned          NumWords  = 2**25,
  localparam int unsigned         BeWidth   = DataWidth / 8,
  localparam int unsigned         ByteOff   = $clog2(BeWidth),
  localparam int unsigned         IdxWidth  = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pl_valid_i,
  output logic                 pl_ready_o,
  input  logic [AddrWidth-1:0] pl_addr_i,
  input  logic [DataWidth-1:0] pl_data_i,
  input  logic                 pl_last_i,
  input  logic                 sys_req_i,
  output logic                 sys_gnt_o,
  input  logic                 sys_we_i,
  input  logic [AddrWidth-1:0] sys_addr_i,
  input  logic [DataWidth-1:0] sys_wdata_i,
  input  logic [BeWidth-1:0]   sys_be_i,
  output logic                 sys_rvalid_o,
  output logic [DataWidth-1:0] sys_rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [IdxWidth-1:0]  mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [BeWidth-1:0]   mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 init_done_o,
  output logic                 oob_err_o
);

  localparam logic [AddrWidth-1:0] Span = AddrWidth'(NumWords) * AddrWidth'(BeWidth);

  typedef enum logic {INIT, RUN} state_e;

  state_e               state_q;
  logic                 lw_q;       // last winner: 0 = preload, 1 = system
  logic                 rvalid_q;
  logic                 oob_q;
  logic [AddrWidth-1:0] pl_off;
  logic [AddrWidth-1:0] sys_off;
  logic                 pl_in_range;
  logic                 run;
  logic                 pl_fire;
  logic                 pl_write;
  logic                 unused_addr_bits;

  assign pl_off      = pl_addr_i - BaseAddr;
  assign sys_off     = sys_addr_i - BaseAddr;
  assign pl_in_range = (pl_addr_i >= BaseAddr) && (pl_off < Span);
  assign run         = (state_q == RUN);

  // When both sides request in RUN, whoever did not win last goes first.
  assign pl_ready_o = !run || !sys_req_i || lw_q;
  assign sys_gnt_o  = run && sys_req_i && (!pl_valid_i || !lw_q);
  assign pl_fire    = pl_valid_i && pl_ready_o;
  assign pl_write   = pl_fire && pl_in_range;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (sys_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = sys_we_i;
      mem_addr_o  = sys_off[ByteOff +: IdxWidth];
      mem_wdata_o = sys_wdata_i;
      mem_be_o    = sys_be_i;
    end else if (pl_write) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = pl_off[ByteOff +: IdxWidth];
      mem_wdata_o = pl_data_i;
      mem_be_o    = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= INIT;
      lw_q     <= 1'b0;
      rvalid_q <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      rvalid_q <= sys_gnt_o && !sys_we_i;
      if (pl_fire) begin
        lw_q <= 1'b0;
        if (!pl_in_range) oob_q <= 1'b1;
        if (pl_last_i && state_q == INIT) state_q <= RUN;
      end else if (sys_gnt_o) begin
        lw_q <= 1'b1;
      end
    end
  end

  assign sys_rvalid_o = rvalid_q;
  assign sys_rdata_o  = mem_rdata_i;
  assign init_done_o  = run;
  assign oob_err_o    = oob_q;

  assign unused_addr_bits = ^{pl_off, sys_off};

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: behavioural DRAM macro, read-return scoreboard, one task per scenario.
module tb_dram_port_arbiter;

  localparam logic [63:0] Base = 64'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pl_valid, pl_ready, pl_last;
  logic [63:0]  pl_addr;
  logic [255:0] pl_data;
  logic         sys_req, sys_gnt, sys_we;
  logic [63:0]  sys_addr;
  logic [255:0] sys_wdata;
  logic [31:0]  sys_be;
  logic         sys_rvalid;
  logic [255:0] sys_rdata;
  logic         mem_req, mem_we;
  logic [24:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_be;
  logic [255:0] mem_rdata;
  logic         init_done, oob_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [255:0] data;
    int           cyc;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  logic [255:0] beat[4];
  logic [255:0] mem_model [int unsigned];
  logic [255:0] wr_tmp;

  dram_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pl_valid_i(pl_valid), .pl_ready_o(pl_ready), .pl_addr_i(pl_addr),
    .pl_data_i(pl_data), .pl_last_i(pl_last),
    .sys_req_i(sys_req), .sys_gnt_o(sys_gnt), .sys_we_i(sys_we),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_be_i(sys_be),
    .sys_rvalid_o(sys_rvalid), .sys_rdata_o(sys_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .init_done_o(init_done), .oob_err_o(oob_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port macro with 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        wr_tmp = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : '0;
        for (int b = 0; b < 32; b++)
          if (mem_be[b]) wr_tmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem_model[int'(mem_addr)] = wr_tmp;
      end else begin
        mem_rdata <= mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : '0;
      end
    end
  end

  // Read-return scoreboard: every expected read is due on a specific cycle, any other rvalid is spurious.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        n_cmp++;
        if (sys_rvalid !== 1'b1 || sys_rdata !== rd_q[0].data) begin
          n_err++;
          $display("FAIL rd_return: rvalid=%b rdata=%h want rvalid=1 rdata=%h", sys_rvalid, sys_rdata, rd_q[0].data);
        end
        void'(rd_q.pop_front());
      end else begin
        n_cmp++;
        if (sys_rvalid !== 1'b0) begin
          n_err++;
          $display("FAIL rd_spurious: rvalid=%b want 0 (cycle %0d)", sys_rvalid, cyc);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pl_valid = 0; pl_last = 0; pl_addr = '0; pl_data = '0;
    sys_req = 0; sys_we = 0; sys_addr = '0; sys_wdata = '0; sys_be = '0;
  endtask

  task automatic test_reset();
    sys_req = 1;
    @(negedge clk);
    n_cmp++; if (pl_ready !== 1'b1)  begin n_err++; $display("FAIL reset_pl_ready: got %b want 1", pl_ready); end
    n_cmp++; if (sys_gnt !== 1'b0)   begin n_err++; $display("FAIL reset_sys_gnt: got %b want 0", sys_gnt); end
    n_cmp++; if (mem_req !== 1'b0)   begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    n_cmp++; if (oob_err !== 1'b0)   begin n_err++; $display("FAIL reset_oob: got %b want 0", oob_err); end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      pl_valid = 1; pl_addr = Base + 64'(i * 32); pl_data = beat[i]; pl_last = (i == 3);
      sys_req = 1; sys_we = 0; sys_addr = Base + 64'h40;
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL pre_mem_we[%0d]: req=%b we=%b want 1/1", i, mem_req, mem_we); end
      n_cmp++; if (mem_addr !== 25'(i)) begin n_err++; $display("FAIL pre_mem_addr[%0d]: got %0d want %0d", i, mem_addr, i); end
      n_cmp++; if (mem_be !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL pre_mem_be[%0d]: got %h want ffffffff", i, mem_be); end
      n_cmp++; if (mem_wdata !== beat[i]) begin n_err++; $display("FAIL pre_mem_wdata[%0d]: got %h want %h", i, mem_wdata, beat[i]); end
      n_cmp++; if (sys_gnt !== 1'b0 || pl_ready !== 1'b1) begin n_err++; $display("FAIL pre_init_gnt[%0d]: gnt=%b rdy=%b want 0/1", i, sys_gnt, pl_ready); end
      n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL pre_init_done[%0d]: got %b want 0", i, init_done); end
    end
    next_cycle();
    pl_valid = 0; pl_last = 0;
    @(negedge clk);
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL pre_run_entry: init_done=%b want 1", init_done); end
    n_cmp++; if (sys_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 25'd2) begin
      n_err++; $display("FAIL pre_first_gnt: gnt=%b we=%b addr=%0d want 1/0/2", sys_gnt, mem_we, mem_addr);
    end
    rd_q.push_back('{beat[2], cyc + 1});
    next_cycle();
    sys_req = 0;
  endtask

  task automatic test_reads();
    logic [63:0] addrs[3];
    int          idx[3];
    addrs[0] = Base + 64'h47; addrs[1] = Base; addrs[2] = Base + 64'h20;
    idx[0] = 2; idx[1] = 0; idx[2] = 1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sys_req = 1; sys_we = 0; sys_addr = addrs[k];
      @(negedge clk);
      n_cmp++; if (sys_gnt !== 1'b1 || mem_addr !== 25'(idx[k])) begin
        n_err++; $display("FAIL read_gnt[%0d]: gnt=%b addr=%0d want 1/%0d", k, sys_gnt, mem_addr, idx[k]);
      end
      rd_q.push_back('{beat[idx[k]], cyc + 1});
    end
    next_cycle();
    sys_req = 0;
    repeat (2) next_cycle();
    n_cmp++; if (rd_q.size() != 0) begin n_err++; $display("FAIL read_drain: %0d reads outstanding want 0", rd_q.size()); end
  endtask

  task automatic test_arbitration();
    logic exp_sys;
    next_cycle();
    pl_valid = 1; pl_addr = Base + 64'(11 * 32); pl_data = {8{32'h1111_2222}}; pl_last = 0;
    @(negedge clk);
    n_cmp++; if (pl_ready !== 1'b1 || mem_addr !== 25'd11) begin n_err++; $display("FAIL arb_solo_pl: rdy=%b addr=%0d want 1/11", pl_ready, mem_addr); end
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      sys_req = 1; sys_we = 1; sys_addr = Base + 64'(10 * 32); sys_wdata = {8{32'h3333_4444}}; sys_be = '1;
      exp_sys = (k % 2 == 0);
      @(negedge clk);
      n_cmp++; if (sys_gnt !== exp_sys || pl_ready !== !exp_sys) begin
        n_err++; $display("FAIL arb_rr[%0d]: gnt=%b rdy=%b want %b/%b", k, sys_gnt, pl_ready, exp_sys, !exp_sys);
      end
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== (exp_sys ? 25'd10 : 25'd11)) begin
        n_err++; $display("FAIL arb_mem[%0d]: req=%b addr=%0d want 1/%0d", k, mem_req, mem_addr, exp_sys ? 10 : 11);
      end
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_sys_write();
    next_cycle();
    sys_req = 1; sys_we = 1; sys_addr = 64'h8000_0005; sys_be = 32'h0000_000F; sys_wdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    n_cmp++; if (sys_gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_err++; $display("FAIL sw_gnt: gnt=%b req=%b we=%b want 1/1/1", sys_gnt, mem_req, mem_we);
    end
    n_cmp++; if (mem_addr !== 25'd0) begin n_err++; $display("FAIL sw_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (mem_be !== 32'h0000_000F) begin n_err++; $display("FAIL sw_be: got %h want 0000000f", mem_be); end
    n_cmp++; if (mem_wdata !== {8{32'hDEAD_BEEF}}) begin n_err++; $display("FAIL sw_wdata: got %h", mem_wdata); end
    next_cycle();
    sys_addr = 64'hC000_0020;
    @(negedge clk);
    n_cmp++; if (mem_addr !== 25'd1) begin n_err++; $display("FAIL sw_wrap: got %0d want 1", mem_addr); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_oob();
    next_cycle();
    rst_n = 0;
    #2 rst_n = 1;
    next_cycle();
    pl_valid = 1; pl_addr = 64'h7FFF_FFE0; pl_data = {8{32'h5555_AAAA}}; pl_last = 0;
    @(negedge clk);
    n_cmp++; if (pl_ready !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL oob_low: rdy=%b req=%b want 1/0", pl_ready, mem_req); end
    next_cycle();
    pl_addr = 64'hC000_0000; pl_last = 1;
    @(negedge clk);
    n_cmp++; if (oob_err !== 1'b1) begin n_err++; $display("FAIL oob_flag: got %b want 1", oob_err); end
    n_cmp++; if (pl_ready !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL oob_high: rdy=%b req=%b want 1/0", pl_ready, mem_req); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL oob_early_run: init_done=%b want 0", init_done); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL oob_run: init_done=%b want 1", init_done); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (oob_err !== 1'b1) begin n_err++; $display("FAIL oob_sticky: got %b want 1", oob_err); end
  endtask

  task automatic test_async_reset();
    next_cycle();
    sys_req = 1; sys_we = 0; sys_addr = Base;
    @(negedge clk);
    n_cmp++; if (sys_gnt !== 1'b1) begin n_err++; $display("FAIL ar_gnt: got %b want 1", sys_gnt); end
    rd_q.push_back('{beat[0], cyc + 1});
    next_cycle();
    n_cmp++; if (sys_rvalid !== 1'b1) begin n_err++; $display("FAIL ar_inflight: rvalid=%b want 1", sys_rvalid); end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (sys_rvalid !== 1'b0) begin n_err++; $display("FAIL ar_rvalid: got %b want 0", sys_rvalid); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL ar_init_done: got %b want 0", init_done); end
    n_cmp++; if (oob_err !== 1'b0) begin n_err++; $display("FAIL ar_oob: got %b want 0", oob_err); end
    rd_q.delete();
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (pl_ready !== 1'b1 || sys_gnt !== 1'b0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL ar_post_init: rdy=%b gnt=%b req=%b want 1/0/0", pl_ready, sys_gnt, mem_req);
    end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL ar_post_state: init_done=%b want 0", init_done); end
    next_cycle();
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      beat[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 28'($urandom), 4'(i)};
    rst_n = 0;
    drive_idle();
    #17 rst_n = 1;
    test_reset();
    test_preload();
    test_reads();
    test_arbitration();
    test_sys_write();
    test_oob();
    test_async_reset();
    repeat (3) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
